icache_nway_ctrl: RTL and testbench
===================================

// Module: icache_nway_ctrl
// PURPOSE
//  Parametrised N-way set-associative instruction cache with its own miss/refill FSM and flush.
//  Sits between instruction fetch (valid/ready request, 1-cycle-pulse response) and the
//  instruction memory (line-wide valid/ready request, valid-only response).
//  Successor to the fixed 4-set/2-way cache: adds configurable geometry, tree pseudo-LRU,
//  handshaked refill, misalignment error, flush and perf counters.
// PARAMETERS
//  ADDR_W          32  byte-address width
//  INSTR_W         32  instruction width; fixed at 32, word-aligned fetch
//  WORDS_PER_LINE   2  instructions per line (power of 2, >=2)
//  SETS             4  number of sets (power of 2, >=2)
//  WAYS             2  associativity (power of 2, 1..8)
//  CNT_W           16  perf counter width
// PORTS
//  clk            in   1                    clock, all state updates on rising edge
//  reset          in   1                    synchronous, active-high
//  req_valid      in   1                    fetch request
//  req_addr       in   ADDR_W               fetch byte address
//  req_ready      out  1                    (state==IDLE)&&!flush&&!flush_pend, combinational
//  rsp_valid      out  1                    one-cycle pulse, no backpressure
//  rsp_instr      out  INSTR_W              instruction, 0 when rsp_err
//  rsp_err        out  1                    misaligned address (req_addr[1:0]!=0)
//  flush          in   1                    invalidate all lines (level sampled per cycle)
//  mem_req_valid  out  1                    line refill request
//  mem_req_addr   out  ADDR_W               line-aligned address (offset bits zero)
//  mem_req_ready  in   1                    memory accepts request
//  mem_rsp_valid  in   1                    refill data valid
//  mem_rsp_data   in   INSTR_W*WORDS_PER_LINE  line, word 0 in LSBs
//  hit_count      out  CNT_W                saturating hit counter
//  miss_count     out  CNT_W                saturating miss counter
// BEHAVIOUR
//  Address split: [1:0] byte, next log2(WORDS_PER_LINE) word, next log2(SETS) set, rest tag.
//  Reset: all valid bits and pLRU bits 0; state IDLE; all outputs 0; counters 0; flush_pend 0.
//  IDLE: handshake req_valid&&req_ready:
//   - misaligned -> next cycle rsp_valid=1, rsp_err=1, rsp_instr=0; no lookup/pLRU/counter change.
//   - hit (valid && tag match, at most one way) -> next cycle rsp_valid=1, rsp_instr=word; pLRU
//     marks hit way MRU; hit_count++. Back-to-back hits: 1 per cycle.
//   - miss -> latch addr; miss_count++; go MISS_REQ.
//  MISS_REQ: mem_req_valid=1, addr stable until mem_req_ready; then MISS_WAIT.
//  MISS_WAIT: on mem_rsp_valid write line into victim (lowest-index invalid way, else pLRU victim),
//   set valid, mark MRU; next cycle rsp_valid=1 with requested word; back to IDLE (or FLUSH).
//  mem_rsp_valid outside MISS_WAIT is ignored.
//  FLUSH: clears valid and pLRU of one set per cycle, set 0..SETS-1 (SETS cycles), then IDLE.
//  flush in IDLE beats a same-cycle request (req_ready=0). flush during MISS_* sets flush_pend;
//   miss completes and responds, then FLUSH. flush while in FLUSH is absorbed.
//  reset mid-miss: mem_req_valid drops the following cycle; late memory response ignored.
//  Counters saturate at all-ones; never wrap.
//  WAYS==1: pLRU logic absent, victim is way 0.
// STRUCTURE
//  icache_pkg: state enum (IDLE, MISS_REQ, MISS_WAIT, FLUSH), clog2 function, derived widths
//   (OFF_W, IDX_W, TAG_W, LINE_W).
//  Sub-module icache_plru: combinational tree-pLRU; per-set WAYS-1 bits in, access way in ->
//   updated bits out; bits in -> victim way out. Tag/data/valid arrays stay in this module.
// TESTING
//  1 reset, fetch 0x100 -> miss, mem_req_addr=0x100, fill {0xB,0xA} -> rsp_instr=0xA, miss_count=1
//  2 then fetch 0x104 -> hit next cycle, rsp_instr=0xB, hit_count=1, no mem_req_valid
//  3 default geometry: fill 0x000,0x020 (set 0), hit 0x000, miss 0x040 -> evicts 0x020;
//    0x000 still hits
//  4 fetch 0x102 -> rsp_err=1, rsp_instr=0, counters unchanged
//  5 flush during MISS_WAIT -> miss response delivered, then 4 cycles req_ready=0,
//    refetch 0x100 misses
//  6 mem_req_ready held 0 for 5 cycles -> mem_req_valid/addr stable; reset mid-wait ->
//    IDLE, late rsp ignored

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the N-way instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        FLUSH     = 2'd3
    } state_t;

    // Ceiling log2, 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Floor log2, used to locate a tree node's level.
    function automatic int flog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) <= value) result = i;
        end
        return result;
    endfunction

    // Derived address-field widths for a given geometry.
    function automatic int off_w(input int words_per_line);
        return 2 + clog2(words_per_line);
    endfunction

    function automatic int idx_w(input int sets);
        return clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int words_per_line, input int sets);
        return addr_w - off_w(words_per_line) - idx_w(sets);
    endfunction

    function automatic int line_w(input int instr_w, input int words_per_line);
        return instr_w * words_per_line;
    endfunction

endpackage

// File: rtl/icache_plru.sv
// Combinational tree pseudo-LRU for one set: update on access and victim select.
// Node n has children 2n+1 / 2n+2; a bit of 1 steers the victim search right.
module icache_plru
    import icache_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int WAY_W  = (WAYS > 1) ? clog2(WAYS) : 1,
    parameter int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic [PLRU_W-1:0] bits_in,
    input  logic [WAY_W-1:0]  access_way,
    output logic [PLRU_W-1:0] bits_out,
    output logic [WAY_W-1:0]  victim
);

    localparam int LVL = clog2(WAYS);

    generate
        if (WAYS > 1) begin : g_tree
            logic [WAYS-1:0]     way_match;
            logic [WAYS*LVL-1:0] level_ok;

            // Nodes on the accessed way's path point away from it.
            for (genvar n = 0; n < WAYS - 1; n++) begin : g_node
                localparam int L = flog2(n + 1);
                localparam int P = n + 1 - (1 << L);
                logic [WAY_W-1:0] prefix;
                assign prefix      = access_way >> (LVL - L);
                assign bits_out[n] = (prefix == WAY_W'(P)) ? ~access_way[LVL-1-L] : bits_in[n];
            end

            // A way is the victim when every node on its path steers toward it.
            for (genvar w = 0; w < WAYS; w++) begin : g_way
                for (genvar l = 0; l < LVL; l++) begin : g_lvl
                    localparam int   N   = (1 << l) - 1 + (w >> (LVL - l));
                    localparam logic DIR = 1'((w >> (LVL - 1 - l)) & 1);
                    assign level_ok[w*LVL+l] = (bits_in[N] == DIR);
                end
                assign way_match[w] = &level_ok[w*LVL +: LVL];
            end

            // Encode the single matching way.
            always_comb begin
                victim = '0;
                for (int i = 0; i < WAYS; i++) begin
                    if (way_match[i]) victim = WAY_W'(i);
                end
            end
        end else begin : g_direct
            assign bits_out = bits_in;
            assign victim   = '0;
        end
    endgenerate

endmodule

// File: rtl/icache_nway_ctrl.sv
// N-way set-associative instruction cache with miss/refill FSM, flush and perf counters.
module icache_nway_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int INSTR_W        = 32,
    parameter int WORDS_PER_LINE = 2,
    parameter int SETS           = 4,
    parameter int WAYS           = 2,
    parameter int CNT_W          = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    input  logic [ADDR_W-1:0]                 req_addr,
    output logic                              req_ready,
    output logic                              rsp_valid,
    output logic [INSTR_W-1:0]                rsp_instr,
    output logic                              rsp_err,
    input  logic                              flush,
    output logic                              mem_req_valid,
    output logic [ADDR_W-1:0]                 mem_req_addr,
    input  logic                              mem_req_ready,
    input  logic                              mem_rsp_valid,
    input  logic [INSTR_W*WORDS_PER_LINE-1:0] mem_rsp_data,
    output logic [CNT_W-1:0]                  hit_count,
    output logic [CNT_W-1:0]                  miss_count
);

    localparam int WORD_W = clog2(WORDS_PER_LINE);
    localparam int OFF_W  = off_w(WORDS_PER_LINE);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, WORDS_PER_LINE, SETS);
    localparam int LINE_W = line_w(INSTR_W, WORDS_PER_LINE);
    localparam int WAY_W  = (WAYS > 1) ? clog2(WAYS) : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    typedef logic [WORDS_PER_LINE-1:0][INSTR_W-1:0] line_t;

    state_t              state;
    state_t              state_next;
    logic [WAYS-1:0]     valid_q [SETS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    line_t               data_q  [SETS][WAYS];
    logic [PLRU_W-1:0]   plru_q  [SETS];
    logic [ADDR_W-OFF_W-1:0] miss_line;
    logic [WORD_W-1:0]   miss_word;
    logic                flush_pend;
    logic [IDX_W-1:0]    flush_idx;

    logic [WORD_W-1:0]   req_word;
    logic [IDX_W-1:0]    req_set;
    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    miss_set;
    logic [TAG_W-1:0]    miss_tag;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    fill_way;
    logic                accept;
    logic                misalign;
    logic                fill;
    logic [IDX_W-1:0]    acc_set;
    logic [WAY_W-1:0]    acc_way;
    logic [PLRU_W-1:0]   plru_next;
    logic [WAY_W-1:0]    plru_victim;
    line_t               mem_line;

    assign req_word  = req_addr[OFF_W-1:2];
    assign req_set   = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_tag   = req_addr[ADDR_W-1:OFF_W+IDX_W];
    assign miss_set  = miss_line[IDX_W-1:0];
    assign miss_tag  = miss_line[ADDR_W-OFF_W-1:IDX_W];
    assign mem_line  = mem_rsp_data;

    assign req_ready     = (state == IDLE) && !flush && !flush_pend;
    assign accept        = req_valid && req_ready;
    assign misalign      = (req_addr[1:0] != 2'b00);
    assign fill          = (state == MISS_WAIT) && mem_rsp_valid;
    assign mem_req_valid = (state == MISS_REQ);
    assign mem_req_addr  = {miss_line, OFF_W'(0)};

    // Tag compare across all ways of the requested set; first match wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Refill target: lowest invalid way, otherwise the pLRU victim.
    always_comb begin
        fill_way = plru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[miss_set][w]) fill_way = WAY_W'(w);
        end
    end

    assign acc_set = (state == MISS_WAIT) ? miss_set : req_set;
    assign acc_way = (state == MISS_WAIT) ? fill_way : hit_way;

    icache_plru #(
        .WAYS   (WAYS),
        .WAY_W  (WAY_W),
        .PLRU_W (PLRU_W)
    ) u_plru (
        .bits_in    (plru_q[acc_set]),
        .access_way (acc_way),
        .bits_out   (plru_next),
        .victim     (plru_victim)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; a flush raised in the same cycle as the refill goes straight to FLUSH.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (flush)                              state_next = FLUSH;
                else if (accept && !misalign && !hit)   state_next = MISS_REQ;
            end
            MISS_REQ: begin
                if (mem_req_ready) state_next = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_rsp_valid) state_next = (flush_pend || flush) ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (flush_idx == IDX_W'(SETS - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Line storage; contents are only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[miss_set][fill_way]  <= miss_tag;
            data_q[miss_set][fill_way] <= mem_line;
        end
    end

    // Valid/pLRU state, miss context, flush sequencing, responses and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            miss_line  <= '0;
            miss_word  <= '0;
            flush_pend <= 1'b0;
            flush_idx  <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_instr  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_instr <= '0;
            case (state)
                IDLE: begin
                    flush_idx <= '0;
                    if (accept) begin
                        if (misalign) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (hit) begin
                            rsp_valid       <= 1'b1;
                            rsp_instr       <= data_q[req_set][hit_way][req_word];
                            plru_q[req_set] <= plru_next;
                            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                        end else begin
                            miss_line <= req_addr[ADDR_W-1:OFF_W];
                            miss_word <= req_word;
                            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
                        end
                    end
                end
                MISS_REQ: begin
                    if (flush) flush_pend <= 1'b1;
                end
                MISS_WAIT: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_rsp_valid) begin
                        valid_q[miss_set][fill_way] <= 1'b1;
                        plru_q[miss_set]            <= plru_next;
                        rsp_valid                   <= 1'b1;
                        rsp_instr                   <= mem_line[miss_word];
                        flush_pend                  <= 1'b0;
                        flush_idx                   <= '0;
                    end
                end
                FLUSH: begin
                    valid_q[flush_idx] <= '0;
                    plru_q[flush_idx]  <= '0;
                    flush_idx          <= flush_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_nway_ctrl.sv
// Self-checking bench for icache_nway_ctrl: scoreboarded responses plus per-scenario checks.
module tb_icache_nway_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic [3:0]  hit_count;
    logic [3:0]  miss_count;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] exp_q[$];
    logic [3:0]  exp_hits = '0;
    logic [3:0]  exp_misses = '0;

    icache_nway_ctrl #(
        .ADDR_W(32), .INSTR_W(32), .WORDS_PER_LINE(2), .SETS(4), .WAYS(2), .CNT_W(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_instr     (rsp_instr),
        .rsp_err       (rsp_err),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    // Backing-memory contents seen by the refill port.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hA;
        if (a == 32'h104) return 32'hB;
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [32:0] expect_of(input logic [31:0] a);
        if (a[1:0] != 2'b00) return {1'b1, 32'h0};
        return {1'b0, mem_word(a)};
    endfunction

    // Scoreboard: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_rsp got instr=%h err=%b, required no response", rsp_instr, rsp_err);
            end else begin
                logic [32:0] exp;
                exp = exp_q.pop_front();
                if ({rsp_err, rsp_instr} !== exp)
                    begin
                        errors++;
                        $display("[TB] FAIL rsp got err=%b instr=%h, required err=%b instr=%h",
                                 rsp_err, rsp_instr, exp[32], exp[31:0]);
                    end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_ready_timeout got %b, required 1", req_ready);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rsp_timeout pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [31:0] a);
        wait_ready();
        req_valid = 1'b1;
        req_addr  = a;
        exp_q.push_back(expect_of(a));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic serve_miss(input logic [31:0] line, input int ready_delay, input bit flush_in_wait);
        int n = 0;
        while (mem_req_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mem_req_timeout got %b, required 1", mem_req_valid);
        end
        checks++;
        if (mem_req_addr !== line) begin
            errors++;
            $display("[TB] FAIL mem_req_addr got %h, required %h", mem_req_addr, line);
        end
        repeat (ready_delay) begin
            @(negedge clk);
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== line) begin
                errors++;
                $display("[TB] FAIL mem_req_stable got valid=%b addr=%h, required 1 %h",
                         mem_req_valid, mem_req_addr, line);
            end
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        if (flush_in_wait) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL req_ready_miss_wait got %b, required 0", req_ready);
            end
        end
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = {mem_word(line + 32'd4), mem_word(line)};
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input bit miss);
        issue(a);
        if (miss) begin
            serve_miss({a[31:3], 3'b000}, 0, 1'b0);
            if (exp_misses != 4'hF) exp_misses++;
        end else if (a[1:0] == 2'b00) begin
            if (exp_hits != 4'hF) exp_hits++;
        end
        drain();
        checks++;
        if (hit_count !== exp_hits) begin
            errors++;
            $display("[TB] FAIL hit_count at %h got %0d, required %0d", a, hit_count, exp_hits);
        end
        checks++;
        if (miss_count !== exp_misses) begin
            errors++;
            $display("[TB] FAIL miss_count at %h got %0d, required %0d", a, miss_count, exp_misses);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL flush_busy cycle %0d got %b, required 0", i, req_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_done got %b, required 1", req_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_instr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rsp got v=%b e=%b i=%h, required 0 0 0", rsp_valid, rsp_err, rsp_instr);
        end
        checks++;
        if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mem got v=%b a=%h, required 0 0", mem_req_valid, mem_req_addr);
        end
        checks++;
        if (hit_count !== 4'd0 || miss_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters got %0d %0d, required 0 0", hit_count, miss_count);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready got %b, required 1", req_ready);
        end
    endtask

    task automatic test_miss_fill();
        fetch(32'h100, 1'b1);
    endtask

    task automatic test_hit();
        issue(32'h104);
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hit_no_mem_req got %b, required 0", mem_req_valid);
        end
        if (exp_hits != 4'hF) exp_hits++;
        drain();
        checks++;
        if (hit_count !== exp_hits) begin
            errors++;
            $display("[TB] FAIL hit_count got %0d, required %0d", hit_count, exp_hits);
        end
    endtask

    task automatic test_back_to_back(input logic [31:0] base, input int n);
        wait_ready();
        req_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            req_addr = base + 32'(4 * (i % 2));
            exp_q.push_back(expect_of(req_addr));
            if (exp_hits != 4'hF) exp_hits++;
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_ready beat %0d got %b, required 1", i, req_ready);
            end
        end
        req_valid = 1'b0;
        drain();
        checks++;
        if (hit_count !== exp_hits) begin
            errors++;
            $display("[TB] FAIL b2b_hit_count got %0d, required %0d", hit_count, exp_hits);
        end
    endtask

    task automatic test_misaligned();
        fetch(32'h102, 1'b0);
    endtask

    task automatic test_eviction();
        do_flush();
        fetch(32'h000, 1'b1);
        fetch(32'h020, 1'b1);
        fetch(32'h000, 1'b0);
        fetch(32'h040, 1'b1);
        fetch(32'h000, 1'b0);
        fetch(32'h020, 1'b1);
    endtask

    task automatic test_flush_during_miss();
        issue(32'h100);
        serve_miss(32'h100, 0, 1'b1);
        if (exp_misses != 4'hF) exp_misses++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pend_flush_busy cycle %0d got %b, required 0", i, req_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pend_flush_done got %b, required 1", req_ready);
        end
        drain();
        fetch(32'h100, 1'b1);
        fetch(32'h000, 1'b1);
    endtask

    task automatic test_reset_mid_miss();
        int n = 0;
        issue(32'h200);
        while (mem_req_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200) begin
                errors++;
                $display("[TB] FAIL stall_stable cycle %0d got v=%b a=%h, required 1 00000200",
                         i, mem_req_valid, mem_req_addr);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_hits   = '0;
        exp_misses = '0;
        checks++;
        if (mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_miss got mem_req_valid=%b req_ready=%b, required 0 1",
                     mem_req_valid, req_ready);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = {32'hDEAD_0204, 32'hDEAD_0200};
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (hit_count !== 4'd0 || miss_count !== 4'd0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL late_rsp got hits=%0d misses=%0d mem_req_valid=%b, required 0 0 0",
                     hit_count, miss_count, mem_req_valid);
        end
        fetch(32'h200, 1'b1);
        fetch(32'h100, 1'b1);
    endtask

    task automatic test_saturation();
        test_back_to_back(32'h200, 20);
        checks++;
        if (hit_count !== 4'hF) begin
            errors++;
            $display("[TB] FAIL hit_saturate got %0d, required 15", hit_count);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_miss_fill();
        test_hit();
        test_back_to_back(32'h100, 4);
        test_misaligned();
        test_eviction();
        test_flush_during_miss();
        test_reset_mid_miss();
        test_saturation();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
